// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: captures a, b and cin on an accepted start, adds one bit
// per clock LSB first, and publishes {cout, sum} after WIDTH cycles with a one-cycle done pulse.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             accept;
  logic             last_bit;
  logic             sum_bit;
  logic             carry_nxt;

  assign sum_bit   = a_sr[0] ^ b_sr[0] ^ carry;
  assign carry_nxt = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  assign last_bit  = (cnt == CW'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create ordering-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        accept    = start;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Operand/result shifters; start seen in RUN never reaches accept, so it is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      carry  <= carry_nxt;
      res_sr <= {sum_bit, res_sr[WIDTH-1:1]};
      cnt    <= cnt + CW'(1);
      if (last_bit) begin
        sum  <= {sum_bit, res_sr[WIDTH-1:1]};
        cout <= carry_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): scoreboard of expected {cout,sum}
// pushed at stimulus time and popped when done is observed.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;

  int           checks = 0;
  int           errors = 0;
  logic [W:0]   sb_q[$];
  logic [W:0]   last_res = '0;

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                       input logic mc);
    return {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mc};
  endfunction

  // Called just after the accepting edge plus 'elapsed' RUN edges; waits for done with
  // a bounded budget, scrambling operands meanwhile, and checks latency and result.
  task automatic wait_result(input int elapsed, input bit idle_after, input bit scramble);
    int         lat  = elapsed;
    bit         seen = 1'b0;
    logic [W:0] exp_v;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL busy_after_accept: got %b expected 1", busy);
    end
    while (!seen && lat < W + 4) begin
      if (scramble) begin
        a   = W'($urandom);
        b   = W'($urandom);
        cin = 1'($urandom);
      end
      tick();
      lat++;
      if (done === 1'b1) begin
        seen = 1'b1;
      end else begin
        checks++;
        if (busy !== 1'b1 || {cout, sum} !== last_res) begin
          errors++;
          $display("FAIL run_hold: busy=%b res=%h expected busy=1 res=%h", busy, {cout, sum},
                   last_res);
        end
      end
    end
    checks++;
    if (!seen || lat != W) begin
      errors++;
      $display("FAIL latency: got %0d cycles (seen=%b) expected %0d", lat, seen, W);
    end
    if (seen) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty: got done with res=%h expected no result", {cout, sum});
      end else begin
        exp_v    = sb_q.pop_front();
        last_res = exp_v;
        if ({cout, sum} !== exp_v || busy !== 1'b0) begin
          errors++;
          $display("FAIL result: got cout/sum=%h busy=%b expected %h busy=0", {cout, sum},
                   busy, exp_v);
        end
      end
    end
    if (idle_after) begin
      tick();
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || {cout, sum} !== last_res) begin
        errors++;
        $display("FAIL done_width: done=%b busy=%b res=%h expected 0 0 %h", done, busy,
                 {cout, sum}, last_res);
      end
    end
  endtask

  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tc);
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    cin   = tc;
    sb_q.push_back(model(ta, tb_v, tc));
    tick();
    start = 1'b0;
    wait_result(0, 1'b1, 1'b1);
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b1;
    a     = '1;
    b     = '1;
    cin   = 1'b1;
    tick();
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: busy=%b done=%b sum=%h cout=%b expected 0 0 00 0", busy, done,
               sum, cout);
    end
    rst   = 1'b0;
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL idle_no_start: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    run_op(8'h00, 8'h00, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0);
    run_op(8'hA5, 8'h5A, 1'b1);
    run_op(8'h3C, 8'h0F, 1'b0);
  endtask

  task automatic test_start_ignored();
    start = 1'b1;
    a     = 8'h10;
    b     = 8'h20;
    cin   = 1'b0;
    sb_q.push_back(model(8'h10, 8'h20, 1'b0));
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'hFF;
    cin   = 1'b1;
    tick();
    start = 1'b0;
    wait_result(3, 1'b1, 1'b0);
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sb_q.size() != 0) begin
      errors++;
      $display("FAIL ignored_start_extra: done=%b busy=%b pending=%0d expected 0 0 0", done,
               busy, sb_q.size());
    end
  endtask

  task automatic test_back_to_back();
    start = 1'b1;
    a     = 8'h01;
    b     = 8'h01;
    cin   = 1'b0;
    sb_q.push_back(model(8'h01, 8'h01, 1'b0));
    tick();
    wait_result(0, 1'b0, 1'b0);
    a   = 8'h80;
    b   = 8'h80;
    cin = 1'b0;
    sb_q.push_back(model(8'h80, 8'h80, 1'b0));
    tick();
    wait_result(0, 1'b0, 1'b0);
    start = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || {cout, sum} !== 9'h100) begin
      errors++;
      $display("FAIL b2b_end: busy=%b done=%b res=%h expected 0 0 100", busy, done, {cout, sum});
    end
  endtask

  task automatic test_reset_mid_run();
    bit spurious = 1'b0;
    start = 1'b1;
    a     = 8'hC3;
    b     = 8'h7E;
    cin   = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst      = 1'b0;
    last_res = '0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_run: busy=%b done=%b sum=%h cout=%b expected 0 0 00 0", busy,
               done, sum, cout);
    end
    for (int i = 0; i < W + 4; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) spurious = 1'b1;
    end
    checks++;
    if (spurious) begin
      errors++;
      $display("FAIL abort_no_done: got activity after reset expected none");
    end
    run_op(8'h3C, 8'h0F, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 1000; i++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 8, sets operand and sum width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 start  input  1  request to begin an addition; sampled on the rising edge of clk.
REQ-005 a  input  WIDTH  first operand; captured when start is accepted.
REQ-006 b  input  WIDTH  second operand; captured when start is accepted.
REQ-007 cin  input  1  carry-in; captured when start is accepted.
REQ-008 busy  output  1  high while an addition is in progress.
REQ-009 done  output  1  one-cycle pulse marking a valid result.
REQ-010 sum  output  WIDTH  registered result, a+b+cin modulo 2^WIDTH.
REQ-011 cout  output  1  registered carry-out of the addition.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 IDLE with start=1 SHALL capture a, b and cin into internal shift/carry registers, clear the bit counter and enter RUN; IDLE with start=0 SHALL remain in IDLE.
REQ-014 RUN SHALL process one bit per cycle, LSB first: sum bit = a_bit XOR b_bit XOR carry, and new carry = majority(a_bit, b_bit, carry).
REQ-015 Each RUN cycle SHALL shift both operand registers right by one and shift the result bit into the MSB of an internal result shift register.
REQ-016 RUN SHALL last exactly WIDTH cycles; on the WIDTH-th RUN edge the FSM SHALL load sum from the internal result register, load cout from the final carry and enter DONE.
REQ-017 Latency: with start accepted at edge n, busy SHALL be high from edge n to edge n+WIDTH, and done SHALL be high from edge n+WIDTH to edge n+WIDTH+1.
REQ-018 done SHALL be high only in DONE, and busy SHALL be high only in RUN.
REQ-019 DONE with start=1 SHALL accept a new operation, following the IDLE capture rules, and enter RUN (back-to-back operation); DONE with start=0 SHALL enter IDLE.
REQ-020 start in RUN SHALL be ignored, with no capture and no effect on the operation in progress.
REQ-021 sum and cout SHALL change only at completion (REQ-016) or reset, and SHALL hold the last result through IDLE and any subsequent RUN.
REQ-022 Operand inputs SHALL be don't-care outside the accepting edge; changes during RUN SHALL NOT affect the result.
REQ-023 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and SHALL NOT wrap within an operation.
REQ-024 Arithmetic SHALL be unsigned; overflow SHALL be reported only through cout.

Reset
REQ-025 rst=1 at a clock edge SHALL force state IDLE and set busy=0, done=0, sum=0, cout=0, and clear all internal registers and the counter.
REQ-026 rst SHALL take priority over start and over any state, including mid-RUN and DONE.
REQ-027 A reset during RUN SHALL abort the operation without producing done; the first start after rst deasserts SHALL be accepted normally.

Verification (WIDTH=8)
REQ-028 a=0x00, b=0x00, cin=0 with one start pulse -> done exactly 8 cycles after the accepting edge, sum=0x00, cout=0.
REQ-029 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1; a=0x3C, b=0x0F, cin=0 -> sum=0x4B, cout=0.
REQ-030 Start a=0x10, b=0x20, then pulse start with a=0xFF, b=0xFF at RUN cycle 3 -> second request ignored; sum=0x30, cout=0, single done pulse.
REQ-031 start held high continuously with a=0x01, b=0x01 then a=0x80, b=0x80 presented at each DONE -> back-to-back results 0x02/cout0, then 0x00/cout1; busy low only during the DONE cycles.
REQ-032 rst asserted at RUN cycle 4 -> next edge busy=0, done=0, sum=0x00, cout=0, no done pulse; a new start then completes correctly.
REQ-033 Random sweep of at least 1000 (a, b, cin) triples, each checked against {cout,sum} = a+b+cin, with done width exactly one cycle.
